// File: rtl/demux_pkg.sv
// Shared definitions for the 16-bit 1-to-2 buffered demultiplexer.
//   WIDTH_DEFAULT / DEPTH_DEFAULT / CNT_W_DEFAULT : default parameter values
//   SEL_A / SEL_B : in_sel encodings (same polarity as the 2:1 operand mux)
//   clog2         : pointer-width helper for the per-port FIFOs
package demux_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 2;
    localparam int CNT_W_DEFAULT = 16;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Ceiling log2; returns at least 1 for any value >= 2.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_fifo_16b.sv
// Single-clock FIFO used once per demux output port.
//   clk, rst      : clock, synchronous active-high reset
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : word to store
//   pop_i         : consumer takes the head word (ignored when empty)
//   head_o        : registered head word
//   valid_o       : FIFO non-empty
//   full_o        : FIFO holds DEPTH words
module demux_fifo_16b
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard both sides so an overflowing push or an underflowing pop is a no-op.
    assign push_ok = push_i && (occ_q != FULL_CNT);
    assign pop_ok  = pop_i && (occ_q != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        unique case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // NOTE: storage is cleared on reset only because the head word must read 0
    // after reset; with DEPTH this small the cost is a handful of reset muxes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (occ_q != '0);
    assign full_o  = (occ_q == FULL_CNT);

endmodule

// File: rtl/demux_16b_1to2_buf.sv
// Registered 1-to-2 demultiplexer with a small FIFO per destination.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_sel    : word and destination (1 = A, 0 = B)
//   in_valid/in_ready : input handshake; ready depends only on in_sel and
//                       registered occupancy (no ready-through path)
//   a_* / b_*         : per-port head word, valid/ready handshake
//   a_count/b_count   : wrapping count of words accepted into each port
module demux_16b_1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic             a_full, b_full;
    logic             accept;
    logic             push_a, push_b;
    logic [CNT_W-1:0] a_count_q, a_count_d;
    logic [CNT_W-1:0] b_count_q, b_count_d;

    // A full FIFO refuses the word even if it is being popped this cycle;
    // the word is taken on the following cycle.
    assign in_ready = !rst && ((in_sel == SEL_B) ? !b_full : !a_full);
    assign accept   = in_valid && in_ready;
    assign push_a   = accept && (in_sel == SEL_A);
    assign push_b   = accept && (in_sel == SEL_B);

    demux_fifo_16b #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_a),
        .push_data_i (in_data),
        .pop_i       (a_ready),
        .head_o      (a_data),
        .valid_o     (a_valid),
        .full_o      (a_full)
    );

    demux_fifo_16b #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_b),
        .push_data_i (in_data),
        .pop_i       (b_ready),
        .head_o      (b_data),
        .valid_o     (b_valid),
        .full_o      (b_full)
    );

    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (push_a) begin
            a_count_d = a_count_q + CNT_W'(1);
        end
        if (push_b) begin
            b_count_d = b_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;

endmodule

// File: tb/tb_demux_16b_1to2_buf.sv
// Self-checking bench for demux_16b_1to2_buf: directed steps from the test
// plan plus a randomized phase, all compared against a queue-based model.
module tb_demux_16b_1to2_buf;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] a_count;
    logic [15:0] b_count;

    int passed = 0;
    int total  = 0;

    // Behavioural model: one queue per port plus plain counters.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] m_a_cnt = 16'h0;
    logic [15:0] m_b_cnt = 16'h0;

    demux_16b_1to2_buf dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update: a port accepts while it holds fewer than DEPTH words
    // (judged before this edge's pop); a pop needs a non-empty queue.
    always @(posedge clk) begin
        bit acc;
        bit pa;
        bit pb;
        if (rst) begin
            qa.delete();
            qb.delete();
            m_a_cnt = 16'h0;
            m_b_cnt = 16'h0;
        end else begin
            acc = in_valid && (in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
            pa  = a_ready && (qa.size() > 0);
            pb  = b_ready && (qb.size() > 0);
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (acc) begin
                if (in_sel) begin
                    qa.push_back(in_data);
                    m_a_cnt = m_a_cnt + 16'd1;
                end else begin
                    qb.push_back(in_data);
                    m_b_cnt = m_b_cnt + 16'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic exp_ready;
        exp_ready = !rst && (in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
        check({tag, ".a_valid"}, {31'd0, a_valid}, {31'd0, qa.size() > 0});
        check({tag, ".b_valid"}, {31'd0, b_valid}, {31'd0, qb.size() > 0});
        check({tag, ".a_count"}, {16'd0, a_count}, {16'd0, m_a_cnt});
        check({tag, ".b_count"}, {16'd0, b_count}, {16'd0, m_b_cnt});
        if (qa.size() > 0) check({tag, ".a_data"}, {16'd0, a_data}, {16'd0, qa[0]});
        if (qb.size() > 0) check({tag, ".b_data"}, {16'd0, b_data}, {16'd0, qb[0]});
    endtask

    // Let inputs settle, optionally compare everything, then cross one edge.
    task automatic cycle(input string tag, input bit do_check);
        #1;
        if (do_check) check_all(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = 16'h0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cycle("reset", 1);
        cycle("reset", 1);
        check("rst_a_data", {16'd0, a_data}, 32'h0);
        check("rst_b_data", {16'd0, b_data}, 32'h0);
        rst     = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'h1);
        repeat (5) cycle("idle", 1);

        // One word to each port
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 16'h1234;
        cycle("send_a", 1);
        check("a_lat_valid", {31'd0, a_valid}, 32'h1);
        check("a_lat_data", {16'd0, a_data}, 32'h1234);
        in_sel  = 1'b0;
        in_data = 16'hABCD;
        cycle("send_b", 1);
        check("b_lat_data", {16'd0, b_data}, 32'hABCD);
        in_valid = 1'b0;
        cycle("idle2", 1);
        check("cnt_a_1", {16'd0, a_count}, 32'h1);
        check("cnt_b_1", {16'd0, b_count}, 32'h1);

        // Fill A, then full-with-pop blocking
        a_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 16'h0001;
        cycle("fill1", 1);
        in_data = 16'h0002;
        cycle("fill2", 1);
        in_data = 16'h0003;
        #1;
        check("a_full_blocks", {31'd0, in_ready}, 32'h0);
        cycle("a_full", 1);
        a_ready = 1'b1;
        #1;
        check("full_with_pop", {31'd0, in_ready}, 32'h0);
        check("a_head_1", {16'd0, a_data}, 32'h0001);
        cycle("pop1", 1);
        check("a_head_2", {16'd0, a_data}, 32'h0002);
        check("third_taken_next", {31'd0, in_ready}, 32'h1);
        cycle("accept3", 1);
        check("a_head_3", {16'd0, a_data}, 32'h0003);
        in_valid = 1'b0;
        cycle("pop3", 1);
        check("a_drained", {31'd0, a_valid}, 32'h0);

        // A full does not stall B
        a_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 16'h7777;
        cycle("fillA1", 1);
        in_data = 16'h8888;
        cycle("fillA2", 1);
        b_ready = 1'b0;
        in_sel  = 1'b0;
        in_data = 16'h5555;
        #1;
        check("b_not_stalled", {31'd0, in_ready}, 32'h1);
        cycle("send_b2", 1);
        check("b_data_5555", {16'd0, b_data}, 32'h5555);
        check("a_unaffected", {16'd0, a_data}, 32'h7777);

        // Reset with 2 words in A, 1 in B, and a word in flight
        rst     = 1'b1;
        in_data = 16'hDEAD;
        #1;
        check("rst_blocks_ready", {31'd0, in_ready}, 32'h0);
        cycle("rst_mid", 1);
        check("rst_mid_a_valid", {31'd0, a_valid}, 32'h0);
        check("rst_mid_b_valid", {31'd0, b_valid}, 32'h0);
        check("rst_mid_counts", {a_count, b_count}, 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        cycle("post_rst_idle", 1);
        check("no_stale", {30'd0, a_valid, b_valid}, 32'h0);
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 16'h0F0F;
        cycle("post_rst_send", 1);
        check("post_rst_data", {16'd0, a_data}, 32'h0F0F);
        check("post_rst_cnt", {16'd0, a_count}, 32'h1);
        in_valid = 1'b0;
        cycle("post_rst_idle2", 1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            a_ready  = 1'($urandom_range(0, 1));
            b_ready  = 1'($urandom_range(0, 1));
            cycle("rand", 1);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        repeat (4) cycle("rand_drain", 1);

        // Counter wrap on A with B untouched
        rst = 1'b1;
        cycle("wrap_rst", 1);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'($urandom);
            cycle("wrap_b", 1);
        end
        in_sel = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 16'($urandom);
            cycle("wrap_fill", 0);
        end
        in_valid = 1'b0;
        cycle("wrap_pre", 1);
        check("a_cnt_ffff", {16'd0, a_count}, 32'hFFFF);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        cycle("wrap_send", 1);
        check("a_cnt_wrap", {16'd0, a_count}, 32'h0);
        check("b_cnt_kept", {16'd0, b_count}, 32'h3);
        in_valid = 1'b0;
        cycle("end", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
